rate_tick_controller: RTL and testbench

Run/stop and rate-select controller for the design's shared programmable tick source. It owns one half-period counter. Given a requested rate from a fixed table, it produces a 50 % duty square wave and a one-cycle tick enable. Rate changes arrive through a valid/ready handshake and take effect only on a full-period boundary, so the output never glitches. Downstream consumers (display scan, game timing, debounce) use `tick` as a clock enable on `clk`.

---
 rtl/rate_tick_controller.sv | 139 +++++++++++++
 tb/tb_rate_tick_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_controller.sv
// Programmable tick source: square wave plus one-cycle tick at a table-selected rate.
// Rate changes are deferred to a full-period boundary so clk_out never glitches.
module rate_tick_controller #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned RESET_IDX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       sel_valid,
  input  logic [3:0] sel_idx,
  output logic       sel_ready,
  output logic       sel_err,
  output logic       clk_out,
  output logic       tick,
  output logic       running,
  output logic [3:0] rate_idx
);

  localparam logic [3:0] NumRates = 4'd10;

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  function automatic logic [26:0] half_for(input int unsigned hz);
    return 27'(CLK_HZ / (2 * hz) - 1);
  endfunction

  state_e      state_q;
  logic [26:0] cnt_q;
  logic        clk_out_q;
  logic        tick_q;
  logic        sel_err_q;
  logic        sel_ready_q;
  logic        running_q;
  logic [3:0]  rate_q;
  logic [3:0]  pend_q;

  logic [26:0] half_cur;
  logic        accept;
  logic        legal;
  logic        at_half;
  logic        boundary;

  always_comb begin
    half_cur = half_for(1);
    case (rate_q)
      4'd0:    half_cur = half_for(1);
      4'd1:    half_cur = half_for(2);
      4'd2:    half_cur = half_for(10);
      4'd3:    half_cur = half_for(20);
      4'd4:    half_cur = half_for(100);
      4'd5:    half_cur = half_for(200);
      4'd6:    half_cur = half_for(400);
      4'd7:    half_cur = half_for(1000);
      4'd8:    half_cur = half_for(10000);
      4'd9:    half_cur = half_for(100000);
      default: half_cur = half_for(1);
    endcase
  end

  assign accept   = sel_valid && sel_ready_q;
  assign legal    = sel_idx < NumRates;
  assign at_half  = cnt_q == half_cur;
  // clk_out is about to fall: the only point where a new rate may be applied.
  assign boundary = at_half && clk_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
      sel_err_q   <= 1'b0;
      sel_ready_q <= 1'b1;
      running_q   <= 1'b0;
      rate_q      <= 4'(RESET_IDX);
      pend_q      <= 4'(RESET_IDX);
    end else begin
      tick_q    <= 1'b0;
      sel_err_q <= accept && !legal;
      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          if (accept && legal) rate_q <= sel_idx;
          if (start && !stop) begin
            state_q     <= StRun;
            running_q   <= 1'b1;
            sel_ready_q <= 1'b1;
          end
        end
        StRun, StPend: begin
          if (stop) begin
            state_q     <= StIdle;
            running_q   <= 1'b0;
            sel_ready_q <= 1'b1;
            cnt_q       <= '0;
            clk_out_q   <= 1'b0;
            if (state_q == StPend) rate_q <= pend_q;
            else if (accept && legal) rate_q <= sel_idx;
          end else begin
            if (at_half) begin
              cnt_q     <= '0;
              clk_out_q <= ~clk_out_q;
              tick_q    <= ~clk_out_q;
            end else begin
              cnt_q <= cnt_q + 27'd1;
            end
            if (state_q == StPend && boundary) begin
              rate_q      <= pend_q;
              state_q     <= StRun;
              sel_ready_q <= 1'b1;
            end else if (state_q == StRun && accept && legal && sel_idx != rate_q) begin
              pend_q      <= sel_idx;
              state_q     <= StPend;
              sel_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          running_q   <= 1'b0;
          sel_ready_q <= 1'b1;
          cnt_q       <= '0;
          clk_out_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sel_ready = sel_ready_q;
  assign sel_err   = sel_err_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign running   = running_q;
  assign rate_idx  = rate_q;

endmodule

// File: tb/tb_rate_tick_controller.sv
// Scoreboard bench for rate_tick_controller at CLK_HZ = 2 MHz (HALF[9]=9, [8]=99, [7]=999).
// Stimulus pushes expected edge cycles; a negedge monitor pops them as the DUT produces edges.
module tb_rate_tick_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       sel_valid;
  logic [3:0] sel_idx;
  logic       sel_ready;
  logic       sel_err;
  logic       clk_out;
  logic       tick;
  logic       running;
  logic [3:0] rate_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_rise[$];
  int exp_fall[$];
  int exp_err[$];

  rate_tick_controller #(
    .CLK_HZ   (2_000_000),
    .RESET_IDX(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .sel_valid(sel_valid),
    .sel_idx  (sel_idx),
    .sel_ready(sel_ready),
    .sel_err  (sel_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .running  (running),
    .rate_idx (rate_idx)
  );

  initial forever #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge when read at a negedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every clk_out rise/tick, fall and sel_err pulse must match the next expected cycle.
  logic prev_clk = 1'b0;
  int   e;
  always @(negedge clk) begin
    if (tick === 1'b1 || (clk_out === 1'b1 && prev_clk == 1'b0)) begin
      total++;
      if (exp_rise.size() == 0) begin
        bad++;
        $display("FAIL rise: unexpected at cycle %0d tick=%b clk_out=%b running=%b",
                 cyc, tick, clk_out, running);
      end else begin
        e = exp_rise.pop_front();
        if (!(e == cyc && tick === 1'b1 && clk_out === 1'b1 && prev_clk == 1'b0 &&
              running === 1'b1)) begin
          bad++;
          $display("FAIL rise: got cycle %0d tick=%b clk_out=%b running=%b, want cycle %0d all 1",
                   cyc, tick, clk_out, running, e);
        end
      end
    end
    if (clk_out === 1'b0 && prev_clk == 1'b1) begin
      total++;
      if (exp_fall.size() == 0) begin
        bad++;
        $display("FAIL fall: unexpected at cycle %0d", cyc);
      end else begin
        e = exp_fall.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL fall: got cycle %0d, want cycle %0d", cyc, e);
        end
      end
    end
    if (sel_err === 1'b1) begin
      total++;
      if (exp_err.size() == 0) begin
        bad++;
        $display("FAIL sel_err: unexpected pulse at cycle %0d", cyc);
      end else begin
        e = exp_err.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL sel_err: got cycle %0d, want cycle %0d", cyc, e);
        end
      end
    end
    prev_clk = (clk_out === 1'b1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int edge_n);
    while (cyc < edge_n) @(negedge clk);
  endtask

  // Present inputs so they are sampled at rising edge edge_n; returns at the negedge after it.
  task automatic drive_at(input int edge_n, input logic s, input logic p, input logic v,
                          input logic [3:0] idx);
    while (cyc < edge_n - 1) @(negedge clk);
    start     = s;
    stop      = p;
    sel_valid = v;
    sel_idx   = idx;
    @(negedge clk);
    start     = 1'b0;
    stop      = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;

    wait_to(3);
    chk("reset_clk_out", 32'(clk_out), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_sel_err", 32'(sel_err), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_sel_ready", 32'(sel_ready), 1);
    chk("reset_rate_idx", 32'(rate_idx), 0);
    rst_n = 1'b1;

    drive_at(5, 1'b0, 1'b0, 1'b1, 4'd9);
    chk("idle_sel_rate_idx", 32'(rate_idx), 9);
    chk("idle_sel_running", 32'(running), 0);

    // Rate 9: first rise 10 after the start edge, then 10 high / 10 low.
    for (int k = 0; k < 5; k++) begin
      exp_rise.push_back(20 + 20 * k);
      exp_fall.push_back(30 + 20 * k);
    end
    drive_at(10, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("start_running", 32'(running), 1);
    chk("start_clk_out", 32'(clk_out), 0);

    drive_at(45, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("start_in_run_running", 32'(running), 1);

    exp_err.push_back(65);
    drive_at(65, 1'b0, 1'b0, 1'b1, 4'd12);
    wait_to(66);
    chk("illegal_rate_idx", 32'(rate_idx), 9);
    chk("illegal_sel_ready", 32'(sel_ready), 1);

    // Request rate 8 mid-high-phase; it lands on the fall at 110.
    exp_rise.push_back(210);
    exp_fall.push_back(310);
    exp_rise.push_back(410);
    exp_fall.push_back(450);
    drive_at(104, 1'b0, 1'b0, 1'b1, 4'd8);
    chk("pend_sel_ready", 32'(sel_ready), 0);
    chk("pend_rate_idx", 32'(rate_idx), 9);
    wait_to(109);
    chk("pend_hold_sel_ready", 32'(sel_ready), 0);
    wait_to(110);
    chk("boundary_sel_ready", 32'(sel_ready), 1);
    chk("boundary_rate_idx", 32'(rate_idx), 8);

    drive_at(420, 1'b0, 1'b0, 1'b1, 4'd7);
    chk("pend7_sel_ready", 32'(sel_ready), 0);
    drive_at(450, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("stop_pend_running", 32'(running), 0);
    chk("stop_pend_clk_out", 32'(clk_out), 0);
    chk("stop_pend_rate_idx", 32'(rate_idx), 7);
    chk("stop_pend_sel_ready", 32'(sel_ready), 1);

    exp_rise.push_back(1480);
    drive_at(480, 1'b1, 1'b0, 1'b0, 4'd0);
    wait_to(1481);
    chk("rate7_rise_seen", exp_rise.size(), 0);

    exp_fall.push_back(1500);
    drive_at(1500, 1'b1, 1'b1, 1'b0, 4'd0);
    chk("start_stop_running", 32'(running), 0);
    chk("start_stop_clk_out", 32'(clk_out), 0);

    drive_at(1510, 1'b1, 1'b0, 1'b0, 4'd0);
    drive_at(1520, 1'b0, 1'b0, 1'b1, 4'd9);
    chk("pend9_sel_ready", 32'(sel_ready), 0);
    chk("pend9_rate_idx", 32'(rate_idx), 7);

    wait_to(1529);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_running", 32'(running), 0);
    chk("midrst_sel_ready", 32'(sel_ready), 1);
    chk("midrst_rate_idx", 32'(rate_idx), 0);
    chk("midrst_clk_out", 32'(clk_out), 0);
    chk("midrst_tick", 32'(tick), 0);
    chk("midrst_sel_err", 32'(sel_err), 0);

    drive_at(1540, 1'b1, 1'b0, 1'b0, 4'd0);
    chk("restart_running", 32'(running), 1);
    wait_to(1700);
    chk("restart_rate_idx", 32'(rate_idx), 0);
    chk("restart_sel_ready", 32'(sel_ready), 1);
    drive_at(1710, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("final_stop_running", 32'(running), 0);
    chk("final_stop_rate_idx", 32'(rate_idx), 0);

    wait_to(1720);
    chk("rise_queue_drained", exp_rise.size(), 0);
    chk("fall_queue_drained", exp_fall.size(), 0);
    chk("err_queue_drained", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
